// File: rtl/fetch_stage.sv
// Instruction-fetch stage: reset-vector load, two-word instruction assembly,
// stall/jump/interrupt handling. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int unsigned      PC_W           = 32,
    parameter logic [PC_W-1:0]  RESET_VEC_ADDR = '0,
    parameter logic [15:0]      NOP_WORD       = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            stall,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            INT_in,
    output logic [PC_W-1:0] PC_out,
    output logic [15:0]     instruction_out,
    output logic [15:0]     Data_out,
    output logic            INT_out,
    output logic            valid_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt,
`endif
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {S_VEC0, S_VEC1, S_FETCH, S_IMM} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     hold_q, hold_d;
    logic            int_pend_q, int_pend_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     data_q, data_d;
    logic            int_out_q, int_out_d;
    logic            valid_q, valid_d;
    logic            int_taken;
    logic            is_two_word;

    assign is_two_word = (imem_data[15:13] == 3'b111);

    always_comb begin
        case (state_q)
            S_VEC0:  imem_addr = RESET_VEC_ADDR;
            S_VEC1:  imem_addr = RESET_VEC_ADDR + PC_W'(1);
            default: imem_addr = pc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        pc_out_d  = pc_out_q;
        instr_d   = instr_q;
        data_d    = data_q;
        int_out_d = int_out_q;
        valid_d   = valid_q;
        int_taken = 1'b0;

        case (state_q)
            S_VEC0: begin
                // The high PC half is parked in the hold register until the low half arrives.
                hold_d    = imem_data;
                instr_d   = NOP_WORD;
                data_d    = '0;
                int_out_d = 1'b0;
                valid_d   = 1'b0;
                state_d   = S_VEC1;
            end
            S_VEC1: begin
                pc_d      = PC_W'({hold_q, imem_data});
                instr_d   = NOP_WORD;
                data_d    = '0;
                int_out_d = 1'b0;
                valid_d   = 1'b0;
                state_d   = S_FETCH;
            end
            default: begin
                if (jmp_en) begin
                    pc_d      = jmp_addr;
                    hold_d    = '0;
                    instr_d   = NOP_WORD;
                    data_d    = '0;
                    int_out_d = 1'b0;
                    valid_d   = 1'b0;
                    state_d   = S_FETCH;
                end else if (!stall) begin
                    if (state_q == S_FETCH) begin
                        if (int_pend_q) begin
                            int_taken = 1'b1;
                            pc_out_d  = pc_q;
                            instr_d   = NOP_WORD;
                            data_d    = '0;
                            int_out_d = 1'b1;
                            valid_d   = 1'b0;
                        end else if (is_two_word) begin
                            hold_d    = imem_data;
                            pc_d      = pc_q + PC_W'(1);
                            instr_d   = NOP_WORD;
                            data_d    = '0;
                            int_out_d = 1'b0;
                            valid_d   = 1'b0;
                            state_d   = S_IMM;
                        end else begin
                            pc_d      = pc_q + PC_W'(1);
                            pc_out_d  = pc_q + PC_W'(1);
                            instr_d   = imem_data;
                            data_d    = '0;
                            int_out_d = 1'b0;
                            valid_d   = 1'b1;
                        end
                    end else begin
                        pc_d      = pc_q + PC_W'(1);
                        pc_out_d  = pc_q + PC_W'(1);
                        instr_d   = hold_q;
                        data_d    = imem_data;
                        int_out_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
        endcase

        // A fresh request in the same cycle a pending one is taken re-arms it.
        int_pend_d = INT_in | (int_pend_q & ~int_taken);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_VEC0;
            pc_q       <= '0;
            hold_q     <= '0;
            int_pend_q <= 1'b0;
            pc_out_q   <= '0;
            instr_q    <= NOP_WORD;
            data_q     <= '0;
            int_out_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            int_pend_q <= int_pend_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            int_out_q  <= int_out_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid_d && !stall)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && (state_q == S_FETCH || state_q == S_IMM))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    assign PC_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign Data_out        = data_q;
    assign INT_out         = int_out_q;
    assign valid_out       = valid_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stall/jump/interrupt/reset traffic checked against a cycle model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        jmp_en;
  logic [31:0] jmp_addr;
  logic        INT_in;
  logic [31:0] PC_out;
  logic [15:0] instruction_out;
  logic [15:0] Data_out;
  logic        INT_out;
  logic        valid_out;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stall(stall),
    .jmp_en(jmp_en),
    .jmp_addr(jmp_addr),
    .INT_in(INT_in),
    .PC_out(PC_out),
    .instruction_out(instruction_out),
    .Data_out(Data_out),
    .INT_out(INT_out),
    .valid_out(valid_out),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt),
    .stall_cnt(stall_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: sparse overrides over a deterministic hashed background
  logic [15:0] mem [logic [31:0]];
  int          mem_gen = 0;

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    logic [31:0] t;
    logic [15:0] h;
    if (mem.exists(a)) return mem[a];
    t = a * 32'h9E37_79B1;
    h = t[23:8];
    if (h[1:0] == 2'b00) h[15:13] = 3'b111;
    return h;
  endfunction

  always @(imem_addr, mem_gen) imem_data = mem_rd(imem_addr);

  task automatic set_mem(input logic [31:0] a, input logic [15:0] d);
    mem[a] = d;
    mem_gen++;
  endtask

  // scoreboard counters
  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // behavioural model
  localparam int M_VEC0 = 0, M_VEC1 = 1, M_FETCH = 2, M_IMM = 3;
  int          m_mode;
  logic [31:0] m_pc;
  logic [15:0] m_hi;
  logic [15:0] m_hold;
  logic        m_intp;
  logic [31:0] e_pcout;
  logic [15:0] e_instr;
  logic [15:0] e_data;
  logic        e_int;
  logic        e_valid;

  function automatic void bubble();
    e_instr = 16'h0000;
    e_data  = 16'h0000;
    e_int   = 1'b0;
    e_valid = 1'b0;
  endfunction

  function automatic logic [31:0] model_addr();
    if (m_mode == M_VEC0) return 32'd0;
    if (m_mode == M_VEC1) return 32'd1;
    return m_pc;
  endfunction

  function automatic void model_step(input logic rst, input logic stl, input logic je,
                                     input logic [31:0] ja, input logic intr);
    logic        next_intp;
    logic [15:0] w;
    if (rst) begin
      m_mode = M_VEC0; m_pc = 0; m_hi = 0; m_hold = 0; m_intp = 0;
      e_pcout = 0;
      bubble();
      return;
    end
    next_intp = intr | m_intp;
    if (m_mode == M_VEC0) begin
      m_hi = mem_rd(32'd0);
      bubble();
      m_mode = M_VEC1;
    end else if (m_mode == M_VEC1) begin
      m_pc = {m_hi, mem_rd(32'd1)};
      bubble();
      m_mode = M_FETCH;
    end else if (je) begin
      m_pc = ja;
      m_mode = M_FETCH;
      bubble();
    end else if (!stl) begin
      w = mem_rd(m_pc);
      if (m_mode == M_FETCH && m_intp) begin
        bubble();
        e_int = 1'b1;
        e_pcout = m_pc;
        next_intp = intr;
      end else if (m_mode == M_FETCH && w[15:13] == 3'b111) begin
        m_hold = w;
        m_pc = m_pc + 1;
        bubble();
        m_mode = M_IMM;
      end else if (m_mode == M_FETCH) begin
        e_instr = w; e_data = 0; e_int = 0; e_valid = 1;
        e_pcout = m_pc + 1;
        m_pc = m_pc + 1;
      end else begin
        e_instr = m_hold; e_data = w; e_int = 0; e_valid = 1;
        e_pcout = m_pc + 1;
        m_pc = m_pc + 1;
        m_mode = M_FETCH;
      end
    end
    m_intp = next_intp;
  endfunction

  // compare process step: applies one cycle of inputs, then checks at the next negedge
  task automatic cycle(input logic rst, input logic stl, input logic je,
                       input logic [31:0] ja, input logic intr);
    reset = rst; stall = stl; jmp_en = je; jmp_addr = ja; INT_in = intr;
    model_step(rst, stl, je, ja, intr);
    @(negedge clk);
    chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    chk("INT_out", {31'd0, INT_out}, {31'd0, e_int});
    chk("instruction_out", {16'd0, instruction_out}, {16'd0, e_instr});
    chk("Data_out", {16'd0, Data_out}, {16'd0, e_data});
    if (e_valid || e_int) chk("PC_out", PC_out, e_pcout);
    chk("imem_addr", imem_addr, model_addr());
  endtask

  task automatic idle(); cycle(0, 0, 0, 32'd0, 0); endtask

  initial begin
    reset = 1; stall = 0; jmp_en = 0; jmp_addr = 0; INT_in = 0;

    // reset vector to 0x0010, one-word instruction
    set_mem(0, 16'h0000); set_mem(1, 16'h0010); set_mem(32'h10, 16'h1234);
    cycle(1, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_pcout", PC_out, 32'd0);
    idle();
    chk("vec0_bubble", {31'd0, valid_out}, 32'd0);
    idle();
    chk("vec1_bubble", {31'd0, valid_out}, 32'd0);
    idle();
    chk("vec_instr", {16'd0, instruction_out}, 32'h1234);
    chk("vec_pcout", PC_out, 32'h11);
    chk("vec_valid", {31'd0, valid_out}, 32'd1);

    // two-word instruction
    set_mem(32'h10, 16'hE200); set_mem(32'h11, 16'h00AB);
    cycle(1, 0, 0, 0, 0); idle(); idle();
    idle();
    chk("imm_bubble", {31'd0, valid_out}, 32'd0);
    idle();
    chk("imm_instr", {16'd0, instruction_out}, 32'hE200);
    chk("imm_data", {16'd0, Data_out}, 32'h00AB);
    chk("imm_pcout", PC_out, 32'h12);

    // jump during the immediate cycle
    set_mem(32'h40, 16'h1111);
    cycle(1, 0, 0, 0, 0); idle(); idle(); idle();
    cycle(0, 0, 1, 32'h40, 0);
    chk("jimm_bubble", {31'd0, valid_out}, 32'd0);
    idle();
    chk("jimm_instr", {16'd0, instruction_out}, 32'h1111);
    chk("jimm_pcout", PC_out, 32'h41);

    // interrupt taken at PC=0x20
    set_mem(1, 16'h001F); set_mem(32'h1F, 16'h2222); set_mem(32'h20, 16'h3333);
    cycle(1, 0, 0, 0, 0); idle(); idle();
    cycle(0, 0, 0, 0, 1);
    chk("int_pre_instr", {16'd0, instruction_out}, 32'h2222);
    idle();
    chk("int_flag", {31'd0, INT_out}, 32'd1);
    chk("int_pcout", PC_out, 32'h20);
    chk("int_valid", {31'd0, valid_out}, 32'd0);
    idle();
    chk("int_post_instr", {16'd0, instruction_out}, 32'h3333);
    chk("int_post_pcout", PC_out, 32'h21);

    // stall freezes everything; stall+jump redirects
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("stall_instr", {16'd0, instruction_out}, 32'h3333);
      chk("stall_addr", imem_addr, 32'h21);
    end
    set_mem(32'h80, 16'h4444);
    cycle(0, 1, 1, 32'h80, 0);
    chk("sj_bubble", {31'd0, valid_out}, 32'd0);
    idle();
    chk("sj_instr", {16'd0, instruction_out}, 32'h4444);
    chk("sj_pcout", PC_out, 32'h81);

    // PC wrap
    set_mem(0, 16'hFFFF); set_mem(1, 16'hFFFF); set_mem(32'hFFFF_FFFF, 16'h5555);
    cycle(1, 0, 0, 0, 0); idle(); idle();
    idle();
    chk("wrap_instr", {16'd0, instruction_out}, 32'h5555);
    chk("wrap_pcout", PC_out, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // randomized traffic
    mem.delete();
    set_mem(0, 16'h0000); set_mem(1, 16'h0100);
    cycle(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_stl, r_je, r_int;
      logic [31:0] r_ja;
      r_rst = ($urandom_range(0, 199) == 0);
      r_stl = ($urandom_range(0, 4) == 0);
      r_je  = ($urandom_range(0, 11) == 0);
      r_int = ($urandom_range(0, 15) == 0);
      r_ja  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      cycle(r_rst, r_stl, r_je, r_ja, r_int);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
